mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and select controller for the shared 4:1 mux (`mux4x1`). It shares the mux among four requesters, issues a one-hot grant, and drives the mux select lines `S1`/`S0` so the granted requester's input reaches `out`. Ownership is held across cycles, so the select lines never change while an owner still has its request asserted, except when the optional hold limit forces a rotation.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner; legal range 1..255; used only when the hold limit is compiled in.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req`  in  4  request per requester; `req[i]` maps to mux input `i{i}`.
- `gnt`  out  4  one-hot grant; all zero when idle.
- `S1`  out  1  mux select MSB, equal to owner index bit 1.
- `S0`  out  1  mux select LSB, equal to owner index bit 0.
- `valid`  out  1  high when a grant is active; equals OR of `gnt`.

## Operation
- **States.**
  - IDLE: no owner.
  - GRANT: `owner` (2 bits) holds the mux.
- **Priority pointer.**
  - `ptr` (2 bits) gives the first index checked.
  - Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4 (wrap 3→0).
  - On every new grant, `ptr` is set to `owner+1` mod 4.
- **IDLE.**
  - If any `req` bit is high: select the first set bit in search order and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT, `req[owner]` high, hold not expired.** Keep the owner and increment `hold_cnt`.
- **GRANT, `req[owner]` low (release).**
  - If any other `req` bit is high, grant the next one in search order on the same edge, with no idle cycle.
  - Otherwise go to IDLE.
- **GRANT, hold expired** (`hold_cnt == MAX_HOLD` and `req[owner]` high).
  - If any other `req` bit is high, rotate to the next one in search order.
  - If no other request is pending, re-grant the same owner and reload `hold_cnt` to 1; `gnt` stays high with no gap.
- **Hold counter.** `hold_cnt` (8 bits) loads 1 on every grant edge. It increments only while the same owner is kept and never exceeds `MAX_HOLD`.
- **Select lines.**
  - `S1`/`S0` update only on a grant edge.
  - In IDLE they hold the last owner's index, so the mux output does not glitch.
- **Outputs.** All outputs are registered; there are no combinational paths from `req` to any output.
- **Reset values.** `gnt`=0000, `valid`=0, `S1`=0, `S0`=0, state IDLE, `ptr`=0, `hold_cnt`=0.
- **Reset mid-operation.** Assertion clears all state immediately, without waiting for a clock edge. After release, arbitration restarts with `req[0]` at highest priority.

## Timing
- `req` is sampled at rising edge k; `gnt`, `valid`, `S1`, `S0` change after edge k. Request-to-grant latency is 1 cycle.
- Release: `req[owner]` is sampled low at edge k, and `gnt` changes (handoff or clear) after edge k. The owner keeps the mux for the cycle in which it drops `req`.
- Preemption limit: an owner keeps `gnt` for at most `MAX_HOLD` consecutive cycles while others are waiting.
- Worst-case wait with all four requesting: 3·`MAX_HOLD` cycles.
- Simultaneous events:
  - New requests arriving on the same edge as a release are eligible in that arbitration.
  - An owner whose `req` drops on its expiry edge is treated as a release.
- Reset removal: the first arbitration happens at the first rising edge after `rst_n` goes high.

## Configuration
- `MUX4_ARB_HOLD_LIMIT_EN` defined:
  - `hold_cnt` and the expiry rule are built in.
  - Preemption happens after `MAX_HOLD` cycles.
- Not defined:
  - No hold counter is built.
  - An owner keeps the grant until it drops `req`; no preemption.
  - `MAX_HOLD` is ignored.

## Test plan
- **Reset.** Hold `rst_n`=0 with `req`=1111 → `gnt`=0000, `valid`=0, `S1S0`=00. Assert `rst_n` between edges during `gnt`=1000 → outputs clear before the next edge. After release with `req`=1001 → `gnt`=0001.
- **Single request.** `req`=0100 for 3 cycles, then 0000 → `gnt`=0100, `S1S0`=10 from the edge after assertion, 3 cycles long. Then `gnt`=0000, `valid`=0, `S1S0` stays 10.
- **Handoff, no gap.** Owner 1 with `req`=0110, then `req` changes to 0100 → `gnt` goes 0010→0100 on the same edge, `S1S0` goes 01→10, `valid` stays high.
- **Full rotation** (`MAX_HOLD`=4, `MUX4_ARB_HOLD_LIMIT_EN` defined). `req`=1111 held → grants 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles, with no idle cycle.
- **Lone owner past the limit** (`MAX_HOLD`=4, EN defined). `req`=0001 for 10 cycles → `gnt`=0001 continuously for 10 cycles, then clears one edge after `req` drops.
- **Hold limit compiled out** (no EN). `req`=1111 for 20 cycles → `gnt`=0001 throughout. Drop `req[0]` → `gnt`=0010 on the next edge.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the S1/S0 select lines of a shared 4:1 mux.
// Define MUX4_ARB_HOLD_LIMIT_EN to build the MAX_HOLD preemption counter.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       S1,
  output logic       S0,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] owner;
  logic [1:0] ptr;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] k;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = start + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  logic [3:0] others;
  logic [2:0] pick_all;
  logic [2:0] pick_oth;
  logic       do_grant;
  logic       do_idle;
  logic [1:0] grant_idx;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt;
  logic       expired;
  assign expired = (hold_cnt == 8'(MAX_HOLD));
`endif

  assign others   = req & ~(4'b0001 << owner);
  assign pick_all = pick(req, ptr);
  assign pick_oth = pick(others, ptr);

  always_comb begin
    do_grant  = 1'b0;
    do_idle   = 1'b0;
    grant_idx = owner;
    if (state == IDLE) begin
      do_grant  = pick_all[2];
      grant_idx = pick_all[1:0];
    end else if (!req[owner]) begin
      // Release: hand off on the same edge if anyone else is waiting.
      do_grant  = pick_oth[2];
      do_idle   = !pick_oth[2];
      grant_idx = pick_oth[1:0];
    end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    else if (expired) begin
      // Lone owner past its limit is simply re-granted with a fresh count.
      do_grant  = 1'b1;
      grant_idx = pick_oth[2] ? pick_oth[1:0] : owner;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      gnt   <= 4'b0000;
      valid <= 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      hold_cnt <= 8'd0;
`endif
    end else if (do_grant) begin
      state <= GRANT;
      owner <= grant_idx;
      ptr   <= grant_idx + 2'd1;
      gnt   <= 4'b0001 << grant_idx;
      valid <= 1'b1;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      hold_cnt <= 8'd1;
`endif
    end else if (do_idle) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      valid <= 1'b0;
    end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    else if (state == GRANT) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
`endif
  end

  // owner only moves on a grant edge, so the select lines hold through IDLE.
  assign S1 = owner[1];
  assign S0 = owner[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed bench for mux4_rr_arbiter against a behavioural
// round-robin model; honours MUX4_ARB_HOLD_LIMIT_EN like the design.
module tb_mux4_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       S1;
  logic       S0;
  logic       valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_sel;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .S1    (S1),
    .S0    (S0),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_sel   = 0;
  endtask

  // First requester at or after 'start' (mod 4), skipping 'skip'; -1 if none.
  function automatic int first_req(input logic [3:0] r, input int start, input int skip);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (start + i) % 4;
      if (r[idx] && idx != skip) return idx;
    end
    return -1;
  endfunction

  task automatic model_grant(input int n);
    m_busy  = 1'b1;
    m_owner = n;
    m_ptr   = (n + 1) % 4;
    m_hold  = 1;
    m_sel   = n;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int nxt;
    if (!m_busy) begin
      nxt = first_req(r, m_ptr, -1);
      if (nxt >= 0) model_grant(nxt);
    end else if (!r[m_owner]) begin
      nxt = first_req(r, m_ptr, m_owner);
      if (nxt >= 0) model_grant(nxt);
      else m_busy = 1'b0;
    end else begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      if (m_hold >= MAXH) begin
        nxt = first_req(r, m_ptr, m_owner);
        model_grant(nxt >= 0 ? nxt : m_owner);
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic check_model(input string where);
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
    chk({where, ".gnt"},   {4'b0, gnt},       {4'b0, eg});
    chk({where, ".valid"}, {7'b0, valid},     {7'b0, m_busy});
    chk({where, ".sel"},   {6'b0, S1, S0},    8'(m_sel));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic [3:0] r, input string where);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_model(where);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt",   {4'b0, gnt},    8'h00);
    chk("rst.valid", {7'b0, valid},  8'h00);
    chk("rst.sel",   {6'b0, S1, S0}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, "single");
      chk("single.gnt", {4'b0, gnt},    8'h04);
      chk("single.sel", {6'b0, S1, S0}, 8'h02);
    end
    cycle(4'b0000, "single_rel");
    chk("single_rel.gnt",   {4'b0, gnt},    8'h00);
    chk("single_rel.valid", {7'b0, valid},  8'h00);
    chk("single_rel.sel",   {6'b0, S1, S0}, 8'h02);

    // Handoff with no gap
    do_reset();
    cycle(4'b0010, "hand");
    cycle(4'b0110, "hand");
    chk("hand.gnt1", {4'b0, gnt}, 8'h02);
    cycle(4'b0100, "hand");
    chk("hand.gnt2",  {4'b0, gnt},    8'h04);
    chk("hand.sel2",  {6'b0, S1, S0}, 8'h02);
    chk("hand.valid", {7'b0, valid},  8'h01);

    // Asynchronous reset mid-grant
    do_reset();
    cycle(4'b1000, "mid");
    chk("mid.gnt", {4'b0, gnt}, 8'h08);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async.gnt",   {4'b0, gnt},    8'h00);
    chk("async.valid", {7'b0, valid},  8'h00);
    chk("async.sel",   {6'b0, S1, S0}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1001, "post_rst");
    chk("post_rst.gnt", {4'b0, gnt}, 8'h01);

    // All requesting: rotation with the limit, fixed owner without it
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(4'b1111, "all");
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      chk("rot.gnt", {4'b0, gnt}, 8'(1 << ((c / MAXH) % 4)));
`else
      chk("hold.gnt", {4'b0, gnt}, 8'h01);
`endif
    end
    cycle(4'b1110, "drop0");
    chk("drop0.gnt", {4'b0, gnt}, 8'h02);

    // Lone owner beyond MAX_HOLD
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cycle(4'b0001, "lone");
      chk("lone.gnt", {4'b0, gnt}, 8'h01);
    end
    cycle(4'b0000, "lone_rel");
    chk("lone_rel.gnt", {4'b0, gnt}, 8'h00);

    // Randomized traffic: each request line toggles occasionally
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      cycle(r, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
